dme_interrogation_ctrl: RTL and testbench

//   Sequences one DME interrogation per PRF period: clears the pulse receiver,

---
 rtl/dme_interrogation_ctrl_pkg.sv | 25 ++
 rtl/dme_interrogation_ctrl_period_timer.sv | 25 ++
 rtl/dme_interrogation_ctrl.sv | 153 +++++++++++++++
 tb/tb_dme_interrogation_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dme_interrogation_ctrl_pkg.sv
// dme_interrogation_ctrl_pkg: shared state encoding, timer width and default timing for the DME interrogator
package dme_interrogation_ctrl_pkg;

    localparam int TIMER_W = 32;

    localparam logic [TIMER_W-1:0] DEF_PRF_TICKS    = 32'd40000;
    localparam logic [TIMER_W-1:0] DEF_LISTEN_TICKS = 32'd30000;
    localparam logic [TIMER_W-1:0] DEF_REPLY_DELAY  = 32'd5000;
    localparam logic [7:0]         DEF_TX_PULSE     = 8'd8;
    localparam logic [7:0]         DEF_MISS_LIMIT   = 8'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TX,
        S_LISTEN,
        S_EVAL,
        S_HOLD
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dme_interrogation_ctrl_period_timer.sv
// dme_interrogation_ctrl_period_timer: free-running up counter with synchronous clear and terminal-count flag
module dme_interrogation_ctrl_period_timer
    import dme_interrogation_ctrl_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TERM = 32'd1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_clear,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_tc
);

    logic [TIMER_W-1:0] r_count;

    // count up every cycle; clear restarts at zero on the following cycle
    always_ff @(posedge clk) begin
        if (!resetn || i_clear) r_count <= '0;
        else                    r_count <= r_count + TIMER_W'(1);
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TERM - TIMER_W'(1));

endmodule

// File: rtl/dme_interrogation_ctrl.sv
// dme_interrogation_ctrl: sequences one DME interrogation per PRF period and turns reply time into range
module dme_interrogation_ctrl
    import dme_interrogation_ctrl_pkg::*;
#(
    parameter logic [TIMER_W-1:0] PRF_TICKS      = DEF_PRF_TICKS,
    parameter logic [TIMER_W-1:0] LISTEN_TICKS   = DEF_LISTEN_TICKS,
    parameter logic [TIMER_W-1:0] REPLY_DELAY    = DEF_REPLY_DELAY,
    parameter logic [7:0]         TX_PULSE_TICKS = DEF_TX_PULSE,
    parameter logic [7:0]         MISS_LIMIT     = DEF_MISS_LIMIT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_enable,
    input  logic               i_rx_valid,
    input  logic [TIMER_W-1:0] i_rx_time,
    output logic               o_rx_resetn,
    output logic               o_rx_start,
    output logic               o_tx_trig,
    output logic [TIMER_W-1:0] o_range_ticks,
    output logic               o_range_valid,
    output logic               o_track_lost,
    output logic [7:0]         o_miss_count,
    output logic               o_busy
);

    generate
        if (!(LISTEN_TICKS + TIMER_W'(TX_PULSE_TICKS) + TIMER_W'(3) < PRF_TICKS)) begin : g_bad_timing
            $error("dme_interrogation_ctrl: LISTEN_TICKS + TX_PULSE_TICKS + 3 must be below PRF_TICKS");
        end
    endgenerate

    state_t             r_state;
    logic               r_rx_valid_d;
    logic [TIMER_W-1:0] r_rx_time;
    logic [TIMER_W-1:0] r_range_ticks;
    logic               r_range_valid;
    logic               r_track_lost;
    logic [7:0]         r_miss_count;
    logic               r_rx_resetn;
    logic               r_rx_start;
    logic               r_tx_trig;

    logic [TIMER_W-1:0] w_per_count;
    logic               w_per_tc;
    logic [TIMER_W-1:0] w_listen_count;
    logic               w_listen_tc;
    logic               w_unused;
    logic               w_abort;
    logic               w_edge;
    logic               w_good;
    logic [7:0]         w_miss_next;

    assign w_abort     = !i_enable && (r_state == S_ARM || r_state == S_TX || r_state == S_LISTEN);
    assign w_edge      = i_rx_valid && !r_rx_valid_d;
    assign w_good      = r_rx_time >= REPLY_DELAY;
    assign w_miss_next = sat_inc8(r_miss_count);
    assign w_unused    = &{1'b0, w_listen_count};

    dme_interrogation_ctrl_period_timer #(.TERM(PRF_TICKS)) u_period (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (r_state == S_IDLE || (r_state == S_HOLD && w_per_tc)),
        .o_count (w_per_count),
        .o_tc    (w_per_tc)
    );

    dme_interrogation_ctrl_period_timer #(.TERM(LISTEN_TICKS)) u_listen (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (r_state != S_LISTEN),
        .o_count (w_listen_count),
        .o_tc    (w_listen_tc)
    );

    // interrogation sequencer; outputs are registered alongside each state change
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_rx_valid_d  <= 1'b0;
            r_rx_time     <= '0;
            r_range_ticks <= '0;
            r_range_valid <= 1'b0;
            r_track_lost  <= 1'b0;
            r_miss_count  <= '0;
            r_rx_resetn   <= 1'b1;
            r_rx_start    <= 1'b0;
            r_tx_trig     <= 1'b0;
        end else begin
            r_rx_valid_d  <= i_rx_valid;
            r_range_valid <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_rx_resetn <= 1'b1;
                r_rx_start  <= 1'b0;
                r_tx_trig   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (i_enable) begin
                        r_state     <= S_ARM;
                        r_rx_resetn <= 1'b0;
                    end
                    S_ARM: begin
                        r_state     <= S_TX;
                        r_rx_resetn <= 1'b1;
                        r_tx_trig   <= 1'b1;
                        r_rx_start  <= 1'b1;
                    end
                    S_TX: if (w_per_count == TIMER_W'(TX_PULSE_TICKS)) begin
                        r_state   <= S_LISTEN;
                        r_tx_trig <= 1'b0;
                    end
                    S_LISTEN: if (w_edge) begin
                        r_state    <= S_EVAL;
                        r_rx_time  <= i_rx_time;
                        r_rx_start <= 1'b0;
                    end else if (w_listen_tc) begin
                        r_state      <= S_HOLD;
                        r_rx_start   <= 1'b0;
                        r_miss_count <= w_miss_next;
                        r_track_lost <= r_track_lost || (w_miss_next >= MISS_LIMIT);
                    end
                    S_EVAL: begin
                        r_state <= S_HOLD;
                        if (w_good) begin
                            r_range_ticks <= r_rx_time - REPLY_DELAY;
                            r_range_valid <= 1'b1;
                            r_miss_count  <= '0;
                            r_track_lost  <= 1'b0;
                        end else begin
                            r_miss_count  <= w_miss_next;
                            r_track_lost  <= r_track_lost || (w_miss_next >= MISS_LIMIT);
                        end
                    end
                    S_HOLD: if (w_per_tc) begin
                        r_state     <= i_enable ? S_ARM : S_IDLE;
                        r_rx_resetn <= !i_enable;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_rx_resetn   = r_rx_resetn;
    assign o_rx_start    = r_rx_start;
    assign o_tx_trig     = r_tx_trig;
    assign o_range_ticks = r_range_ticks;
    assign o_range_valid = r_range_valid;
    assign o_track_lost  = r_track_lost;
    assign o_miss_count  = r_miss_count;
    assign o_busy        = r_state != S_IDLE;

endmodule

// File: tb/tb_dme_interrogation_ctrl.sv
// tb_dme_interrogation_ctrl: directed scenarios for the DME interrogation controller with scaled timing
module tb_dme_interrogation_ctrl;

    localparam logic [31:0] PRF    = 32'd200;
    localparam logic [31:0] LISTEN = 32'd150;
    localparam logic [31:0] RD     = 32'd20;
    localparam logic [7:0]  TXP    = 8'd4;
    localparam logic [7:0]  ML     = 8'd3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_enable;
    logic        i_rx_valid;
    logic [31:0] i_rx_time;
    logic        o_rx_resetn;
    logic        o_rx_start;
    logic        o_tx_trig;
    logic [31:0] o_range_ticks;
    logic        o_range_valid;
    logic        o_track_lost;
    logic [7:0]  o_miss_count;
    logic        o_busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    dme_interrogation_ctrl #(
        .PRF_TICKS      (PRF),
        .LISTEN_TICKS   (LISTEN),
        .REPLY_DELAY    (RD),
        .TX_PULSE_TICKS (TXP),
        .MISS_LIMIT     (ML)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_enable      (i_enable),
        .i_rx_valid    (i_rx_valid),
        .i_rx_time     (i_rx_time),
        .o_rx_resetn   (o_rx_resetn),
        .o_rx_start    (o_rx_start),
        .o_tx_trig     (o_tx_trig),
        .o_range_ticks (o_range_ticks),
        .o_range_valid (o_range_valid),
        .o_track_lost  (o_track_lost),
        .o_miss_count  (o_miss_count),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_arm(output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_rx_resetn && n < 500);
        t = cyc;
        if (o_rx_resetn) begin
            checks++;
            errors++;
            $display("FAIL wait_arm: rx_resetn never went low within %0d cycles", n);
        end
    endtask

    task automatic wait_start_rise();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rx_start && n < 500);
        if (!o_rx_start) begin
            checks++;
            errors++;
            $display("FAIL wait_start_rise: rx_start never rose within %0d cycles", n);
        end
    endtask

    task automatic count_start_high(output int n);
        n = 0;
        while (o_rx_start && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (o_rx_start) begin
            checks++;
            errors++;
            $display("FAIL count_start_high: rx_start still high after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        i_enable   = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_time  = '0;
        repeat (3) @(negedge clk);
        checks++; if (o_rx_resetn !== 1'b1) begin errors++; $display("FAIL reset_rx_resetn: got %b expected 1", o_rx_resetn); end
        checks++; if (o_rx_start !== 1'b0) begin errors++; $display("FAIL reset_rx_start: got %b expected 0", o_rx_start); end
        checks++; if (o_tx_trig !== 1'b0) begin errors++; $display("FAIL reset_tx_trig: got %b expected 0", o_tx_trig); end
        checks++; if (o_range_ticks !== 32'd0) begin errors++; $display("FAIL reset_range: got %0d expected 0", o_range_ticks); end
        checks++; if (o_range_valid !== 1'b0) begin errors++; $display("FAIL reset_range_valid: got %b expected 0", o_range_valid); end
        checks++; if (o_track_lost !== 1'b0) begin errors++; $display("FAIL reset_track_lost: got %b expected 0", o_track_lost); end
        checks++; if (o_miss_count !== 8'd0) begin errors++; $display("FAIL reset_miss: got %0d expected 0", o_miss_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_no_enable_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_good_reply();
        int t0, t1, ntx;
        i_enable = 1'b1;
        wait_arm(t0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL arm_busy: got %b expected 1", o_busy); end
        checks++; if (o_tx_trig !== 1'b0) begin errors++; $display("FAIL arm_tx_trig: got %b expected 0", o_tx_trig); end
        @(negedge clk);
        checks++; if (o_rx_resetn !== 1'b1) begin errors++; $display("FAIL arm_one_cycle: rx_resetn got %b expected 1", o_rx_resetn); end
        ntx = (o_tx_trig === 1'b1) ? 1 : 0;
        repeat (7) begin
            @(negedge clk);
            if (o_tx_trig === 1'b1) ntx++;
        end
        checks++; if (ntx != 4) begin errors++; $display("FAIL tx_width: got %0d cycles expected 4", ntx); end
        checks++; if (o_rx_start !== 1'b1) begin errors++; $display("FAIL listen_rx_start: got %b expected 1", o_rx_start); end
        i_rx_time  = 32'd120;
        i_rx_valid = 1'b1;
        @(negedge clk);
        checks++; if (o_rx_start !== 1'b0) begin errors++; $display("FAIL eval_rx_start: got %b expected 0", o_rx_start); end
        @(negedge clk);
        checks++; if (o_range_valid !== 1'b1) begin errors++; $display("FAIL good_range_valid: got %b expected 1", o_range_valid); end
        checks++; if (o_range_ticks !== 32'd100) begin errors++; $display("FAIL good_range: got %0d expected 100", o_range_ticks); end
        @(negedge clk);
        checks++; if (o_range_valid !== 1'b0) begin errors++; $display("FAIL range_valid_pulse: got %b expected 0", o_range_valid); end
        i_rx_valid = 1'b0;
        wait_arm(t1);
        checks++; if (t1 - t0 != 200) begin errors++; $display("FAIL prf_period: got %0d cycles expected 200", t1 - t0); end
    endtask

    task automatic test_misses();
        int n;
        for (int i = 1; i <= 3; i++) begin
            wait_start_rise();
            count_start_high(n);
            if (i == 1) begin
                checks++; if (n != 154) begin errors++; $display("FAIL listen_timeout_len: got %0d expected 154", n); end
            end
            checks++; if (o_miss_count !== 8'(i)) begin errors++; $display("FAIL miss_count_%0d: got %0d expected %0d", i, o_miss_count, i); end
            checks++; if (o_track_lost !== (i >= 3)) begin errors++; $display("FAIL track_lost_%0d: got %b expected %b", i, o_track_lost, i >= 3); end
        end
        wait_start_rise();
        repeat (20) @(negedge clk);
        i_rx_time  = 32'd130;
        i_rx_valid = 1'b1;
        count_start_high(n);
        @(negedge clk);
        checks++; if (o_range_ticks !== 32'd110) begin errors++; $display("FAIL recover_range: got %0d expected 110", o_range_ticks); end
        checks++; if (o_miss_count !== 8'd0) begin errors++; $display("FAIL recover_miss: got %0d expected 0", o_miss_count); end
        checks++; if (o_track_lost !== 1'b0) begin errors++; $display("FAIL recover_track_lost: got %b expected 0", o_track_lost); end
        i_rx_valid = 1'b0;
    endtask

    task automatic test_held_valid();
        int n;
        wait_start_rise();
        repeat (20) @(negedge clk);
        i_rx_time  = 32'd60;
        i_rx_valid = 1'b1;
        count_start_high(n);
        @(negedge clk);
        checks++; if (o_range_ticks !== 32'd40) begin errors++; $display("FAIL held_first_range: got %0d expected 40", o_range_ticks); end
        wait_start_rise();
        count_start_high(n);
        checks++; if (n != 154) begin errors++; $display("FAIL held_no_edge_len: got %0d expected 154", n); end
        checks++; if (o_miss_count !== 8'd1) begin errors++; $display("FAIL held_miss: got %0d expected 1", o_miss_count); end
        checks++; if (o_range_ticks !== 32'd40) begin errors++; $display("FAIL held_range_kept: got %0d expected 40", o_range_ticks); end
        i_rx_valid = 1'b0;
    endtask

    task automatic test_short_rx_time();
        int n;
        wait_start_rise();
        repeat (30) @(negedge clk);
        i_rx_time  = 32'd15;
        i_rx_valid = 1'b1;
        count_start_high(n);
        @(negedge clk);
        checks++; if (o_range_valid !== 1'b0) begin errors++; $display("FAIL short_range_valid: got %b expected 0", o_range_valid); end
        checks++; if (o_miss_count !== 8'd2) begin errors++; $display("FAIL short_miss: got %0d expected 2", o_miss_count); end
        checks++; if (o_range_ticks !== 32'd40) begin errors++; $display("FAIL short_range_kept: got %0d expected 40", o_range_ticks); end
        checks++; if (o_track_lost !== 1'b0) begin errors++; $display("FAIL short_track_lost: got %b expected 0", o_track_lost); end
        i_rx_valid = 1'b0;
    endtask

    task automatic test_edge_at_timeout();
        wait_start_rise();
        repeat (153) @(negedge clk);
        checks++; if (o_rx_start !== 1'b1) begin errors++; $display("FAIL last_listen_rx_start: got %b expected 1", o_rx_start); end
        i_rx_time  = 32'd77;
        i_rx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (o_range_valid !== 1'b1) begin errors++; $display("FAIL tie_range_valid: got %b expected 1", o_range_valid); end
        checks++; if (o_range_ticks !== 32'd57) begin errors++; $display("FAIL tie_range: got %0d expected 57", o_range_ticks); end
        checks++; if (o_miss_count !== 8'd0) begin errors++; $display("FAIL tie_miss: got %0d expected 0", o_miss_count); end
        i_rx_valid = 1'b0;
    endtask

    task automatic test_enable_abort();
        wait_start_rise();
        repeat (10) @(negedge clk);
        i_enable = 1'b0;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
        checks++; if (o_rx_start !== 1'b0) begin errors++; $display("FAIL abort_rx_start: got %b expected 0", o_rx_start); end
        checks++; if (o_tx_trig !== 1'b0) begin errors++; $display("FAIL abort_tx_trig: got %b expected 0", o_tx_trig); end
        checks++; if (o_range_ticks !== 32'd57) begin errors++; $display("FAIL abort_range_kept: got %0d expected 57", o_range_ticks); end
        checks++; if (o_miss_count !== 8'd0) begin errors++; $display("FAIL abort_no_miss: got %0d expected 0", o_miss_count); end
        repeat (5) @(negedge clk);
        checks++; if (o_busy !== 1'b0 || o_range_valid !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: busy %b range_valid %b expected 0 0", o_busy, o_range_valid); end
    endtask

    task automatic test_reset_abort();
        int n;
        i_enable = 1'b1;
        wait_start_rise();
        count_start_high(n);
        checks++; if (o_miss_count !== 8'd1) begin errors++; $display("FAIL pre_reset_miss: got %0d expected 1", o_miss_count); end
        wait_start_rise();
        checks++; if (o_tx_trig !== 1'b1) begin errors++; $display("FAIL pre_reset_tx_trig: got %b expected 1", o_tx_trig); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (o_tx_trig !== 1'b0 || o_rx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_outputs: tx_trig %b rx_start %b expected 0 0", o_tx_trig, o_rx_start); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
        checks++; if (o_range_ticks !== 32'd0) begin errors++; $display("FAIL rst_range: got %0d expected 0", o_range_ticks); end
        checks++; if (o_miss_count !== 8'd0 || o_track_lost !== 1'b0) begin errors++; $display("FAIL rst_miss_track: miss %0d track_lost %b expected 0 0", o_miss_count, o_track_lost); end
        i_enable = 1'b0;
        resetn   = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_busy !== 1'b0 || o_rx_resetn !== 1'b1) begin errors++; $display("FAIL post_rst_idle: busy %b rx_resetn %b expected 0 1", o_busy, o_rx_resetn); end
    endtask

    initial begin
        test_reset();
        test_good_reply();
        test_misses();
        test_held_valid();
        test_short_rx_time();
        test_edge_at_timeout();
        test_enable_abort();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
